// File: rtl/hangman_input_loader_if.sv
// rtl/hangman_input_loader_if.sv - byte/game handshake bundle for hangman_input_loader
//
// Purpose: groups the received-byte stream, the game-logic status lines and
// every loader output so they travel as one port.
// Signals:
//   rx_data[7:0], rx_valid      received ASCII byte and its one-cycle strobe
//   game_rdy, game_over         status from the game logic
//   setWord[39:0]               secret word, first letter in [39:32]
//   guess[7:0]                  current accepted guess (uppercase)
//   toggle_state                one-cycle round-start pulse
//   letter_count[2:0]           letters entered so far
//   used_mask[25:0]             bit i set once 'A'+i has been guessed
//   guess_new, dup_guess, drop  one-cycle result pulses
//   phase[1:0]                  ENTRY=0, START=1, PLAY=2, DONE=3
// Modports: master drives bytes/status and observes outputs; slave is the loader.

interface hangman_input_loader_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        game_rdy;
  logic        game_over;
  logic [39:0] setWord;
  logic [7:0]  guess;
  logic        toggle_state;
  logic [2:0]  letter_count;
  logic [25:0] used_mask;
  logic        guess_new;
  logic        dup_guess;
  logic        drop;
  logic [1:0]  phase;

  modport master (
    output rx_data, rx_valid, game_rdy, game_over,
    input  setWord, guess, toggle_state, letter_count, used_mask,
           guess_new, dup_guess, drop, phase
  );

  modport slave (
    input  rx_data, rx_valid, game_rdy, game_over,
    output setWord, guess, toggle_state, letter_count, used_mask,
           guess_new, dup_guess, drop, phase
  );
endinterface

// File: rtl/hangman_input_loader.sv
// rtl/hangman_input_loader.sv - ASCII byte front end: secret word entry and guess filter
//
// Purpose: collects a 5-letter secret word in ENTRY, strobes toggle_state in
// START, then forwards only new, uppercase, never-guessed letters in PLAY.
// Escape returns to ENTRY from any phase with all state cleared.
// Ports:
//   clk   system clock
//   nRst  asynchronous active-low reset
//   bus   hangman_input_loader_if.slave (bytes, game status, all outputs)
// All outputs are registered.

module hangman_input_loader (
  input  logic                         clk,
  input  logic                         nRst,
  hangman_input_loader_if.slave        bus
);

  typedef enum logic [1:0] {
    ENTRY = 2'd0,
    START = 2'd1,
    PLAY  = 2'd2,
    DONE  = 2'd3
  } phase_t;

  localparam logic [7:0] CH_ESC = 8'h1B;
  localparam logic [7:0] CH_BS  = 8'h08;
  localparam logic [7:0] CH_CR  = 8'h0D;

  phase_t      phase_q, phase_d;
  logic        pending_q, pending_d;
  logic [39:0] word_q, word_d;
  logic [7:0]  guess_q, guess_d;
  logic [2:0]  count_q, count_d;
  logic [25:0] mask_q, mask_d;
  logic        toggle_q, toggle_d;
  logic        new_q, new_d;
  logic        dup_q, dup_d;
  logic        drop_q, drop_d;

  logic        is_lower, is_upper, is_letter;
  logic [7:0]  upper;
  logic [25:0] letter_bit;

  always_comb begin
    is_lower   = (bus.rx_data >= 8'h61) && (bus.rx_data <= 8'h7A);
    is_upper   = (bus.rx_data >= 8'h41) && (bus.rx_data <= 8'h5A);
    is_letter  = is_lower || is_upper;
    upper      = is_lower ? (bus.rx_data - 8'h20) : bus.rx_data;
    letter_bit = 26'd1 << (upper - 8'h41);
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      phase_q   <= ENTRY;
      pending_q <= 1'b0;
      word_q    <= '0;
      guess_q   <= '0;
      count_q   <= '0;
      mask_q    <= '0;
      toggle_q  <= 1'b0;
      new_q     <= 1'b0;
      dup_q     <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      pending_q <= pending_d;
      word_q    <= word_d;
      guess_q   <= guess_d;
      count_q   <= count_d;
      mask_q    <= mask_d;
      toggle_q  <= toggle_d;
      new_q     <= new_d;
      dup_q     <= dup_d;
      drop_q    <= drop_d;
    end
  end

  always_comb begin
    phase_d   = phase_q;
    pending_d = pending_q;
    word_d    = word_q;
    guess_d   = guess_q;
    count_d   = count_q;
    mask_d    = mask_q;
    toggle_d  = 1'b0;
    new_d     = 1'b0;
    dup_d     = 1'b0;
    drop_d    = 1'b0;

    if (bus.rx_valid && (bus.rx_data == CH_ESC)) begin
      phase_d   = ENTRY;
      pending_d = 1'b0;
      word_d    = '0;
      guess_d   = '0;
      count_d   = '0;
      mask_d    = '0;
    end else begin
      unique case (phase_q)
        ENTRY: begin
          if (pending_q) begin
            // Enter was accepted last cycle; the registered toggle_state
            // pulse lines up with the START phase value.
            phase_d   = START;
            pending_d = 1'b0;
            toggle_d  = 1'b1;
            drop_d    = bus.rx_valid;
          end else if (bus.rx_valid) begin
            if (is_letter) begin
              if (count_q < 3'd5) begin
                word_d  = {word_q[31:0], upper};
                count_d = count_q + 3'd1;
              end else begin
                drop_d = 1'b1;
              end
            end else if (bus.rx_data == CH_BS) begin
              if (count_q != 3'd0) begin
                word_d  = {8'h00, word_q[39:8]};
                count_d = count_q - 3'd1;
              end else begin
                drop_d = 1'b1;
              end
            end else if (bus.rx_data == CH_CR) begin
              if (count_q == 3'd5) pending_d = 1'b1;
              else                 drop_d    = 1'b1;
            end else begin
              drop_d = 1'b1;
            end
          end
        end

        START: begin
          phase_d = PLAY;
          mask_d  = '0;
          guess_d = '0;
          drop_d  = bus.rx_valid;
        end

        PLAY: begin
          if (bus.game_over) begin
            phase_d = DONE;
            drop_d  = bus.rx_valid;
          end else if (bus.rx_valid) begin
            if (!is_letter || !bus.game_rdy) begin
              drop_d = 1'b1;
            end else if ((mask_q & letter_bit) != '0) begin
              dup_d = 1'b1;
            end else begin
              // guess only moves here, so it is stable during the compare sweep
              guess_d = upper;
              mask_d  = mask_q | letter_bit;
              new_d   = 1'b1;
            end
          end
        end

        DONE: begin
          drop_d = bus.rx_valid;
        end

        default: phase_d = ENTRY;
      endcase
    end
  end

  assign bus.setWord      = word_q;
  assign bus.guess        = guess_q;
  assign bus.toggle_state = toggle_q;
  assign bus.letter_count = count_q;
  assign bus.used_mask    = mask_q;
  assign bus.guess_new    = new_q;
  assign bus.dup_guess    = dup_q;
  assign bus.drop         = drop_q;
  assign bus.phase        = phase_q;

endmodule

// File: tb/tb_hangman_input_loader.sv
// tb/tb_hangman_input_loader.sv - directed self-checking bench for hangman_input_loader

module tb_hangman_input_loader;

  logic clk;
  logic nRst;
  int   n_cmp;
  int   n_bad;

  hangman_input_loader_if bus ();

  hangman_input_loader dut (
    .clk  (clk),
    .nRst (nRst),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; presents one byte for the next posedge and returns
  // at the following negedge, where the registered result is visible.
  task automatic send(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic enter_word_and_play();
    send(8'h50); send(8'h4C); send(8'h41); send(8'h4E); send(8'h54);
    send(8'h0D);
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    nRst          = 1'b0;
    bus.rx_data   = 8'h00;
    bus.rx_valid  = 1'b0;
    bus.game_rdy  = 1'b0;
    bus.game_over = 1'b0;
    @(negedge clk);
    @(negedge clk);

    chk("rst_phase", 64'(bus.phase), 64'd0);
    chk("rst_word", 64'(bus.setWord), 64'd0);
    chk("rst_guess", 64'(bus.guess), 64'd0);
    chk("rst_count", 64'(bus.letter_count), 64'd0);
    chk("rst_mask", 64'(bus.used_mask), 64'd0);
    chk("rst_pulses", 64'({bus.toggle_state, bus.guess_new, bus.dup_guess, bus.drop}), 64'd0);

    nRst = 1'b1;
    @(negedge clk);

    // word entry "hello" + Enter
    send(8'h68); send(8'h65); send(8'h6C); send(8'h6C); send(8'h6F);
    chk("hello_word", 64'(bus.setWord), 64'h48454C4C4F);
    chk("hello_count", 64'(bus.letter_count), 64'd5);
    send(8'h0D);
    chk("enter_n_phase", 64'(bus.phase), 64'd0);
    chk("enter_n_toggle", 64'(bus.toggle_state), 64'd0);
    @(negedge clk);
    chk("start_toggle", 64'(bus.toggle_state), 64'd1);
    chk("start_phase", 64'(bus.phase), 64'd1);
    @(negedge clk);
    chk("play_toggle_low", 64'(bus.toggle_state), 64'd0);
    chk("play_phase", 64'(bus.phase), 64'd2);
    @(negedge clk);
    chk("play_toggle_still_low", 64'(bus.toggle_state), 64'd0);
    chk("play_word_held", 64'(bus.setWord), 64'h48454C4C4F);

    // escape back to entry
    send(8'h1B);
    chk("esc1_phase", 64'(bus.phase), 64'd0);
    chk("esc1_word", 64'(bus.setWord), 64'd0);
    chk("esc1_count", 64'(bus.letter_count), 64'd0);

    // backspace with empty word, then overflow
    send(8'h08);
    chk("bs_empty_drop", 64'(bus.drop), 64'd1);
    send(8'h41); send(8'h42); send(8'h43); send(8'h44); send(8'h45);
    chk("abcde_drop", 64'(bus.drop), 64'd0);
    send(8'h46);
    chk("overflow_drop", 64'(bus.drop), 64'd1);
    chk("overflow_word", 64'(bus.setWord), 64'h4142434445);
    send(8'h08);
    chk("bs_word", 64'(bus.setWord), 64'h0041424344);
    chk("bs_count", 64'(bus.letter_count), 64'd4);
    chk("bs_drop", 64'(bus.drop), 64'd0);
    send(8'h0D);
    chk("short_enter_drop", 64'(bus.drop), 64'd1);
    chk("short_enter_phase", 64'(bus.phase), 64'd0);
    send(8'h31);
    chk("entry_digit_drop", 64'(bus.drop), 64'd1);
    send(8'h45);
    chk("refill_word", 64'(bus.setWord), 64'h4142434445);
    send(8'h0D);
    @(negedge clk);
    @(negedge clk);
    chk("play2_phase", 64'(bus.phase), 64'd2);
    chk("play2_mask", 64'(bus.used_mask), 64'd0);

    // guess filter
    bus.game_rdy = 1'b1;
    send(8'h71);
    chk("q_guess", 64'(bus.guess), 64'h51);
    chk("q_new", 64'(bus.guess_new), 64'd1);
    chk("q_mask", 64'(bus.used_mask), 64'h0010000);
    send(8'h51);
    chk("Q_dup", 64'(bus.dup_guess), 64'd1);
    chk("Q_new_low", 64'(bus.guess_new), 64'd0);
    chk("Q_guess", 64'(bus.guess), 64'h51);

    // busy drop
    bus.game_rdy = 1'b0;
    send(8'h5A);
    chk("busy_drop", 64'(bus.drop), 64'd1);
    chk("busy_guess", 64'(bus.guess), 64'h51);
    chk("busy_mask", 64'(bus.used_mask), 64'h0010000);
    bus.game_rdy = 1'b1;
    send(8'h21);
    chk("play_punct_drop", 64'(bus.drop), 64'd1);
    send(8'h61);
    chk("a_guess", 64'(bus.guess), 64'h41);
    chk("a_mask", 64'(bus.used_mask), 64'h0010001);

    // end and restart
    bus.game_over = 1'b1;
    send(8'h42);
    bus.game_over = 1'b0;
    chk("over_drop", 64'(bus.drop), 64'd1);
    chk("over_phase", 64'(bus.phase), 64'd3);
    chk("over_mask", 64'(bus.used_mask), 64'h0010001);
    send(8'h43);
    chk("done_drop", 64'(bus.drop), 64'd1);
    chk("done_guess", 64'(bus.guess), 64'h41);
    chk("done_word", 64'(bus.setWord), 64'h4142434445);
    send(8'h1B);
    chk("esc2_phase", 64'(bus.phase), 64'd0);
    chk("esc2_all", 64'({bus.setWord, bus.guess, bus.letter_count}), 64'd0);
    chk("esc2_mask", 64'(bus.used_mask), 64'd0);

    // asynchronous reset while in PLAY
    enter_word_and_play();
    chk("play3_phase", 64'(bus.phase), 64'd2);
    send(8'h6B);
    chk("k_guess", 64'(bus.guess), 64'h4B);
    #2;
    nRst = 1'b0;
    #1;
    chk("arst_phase", 64'(bus.phase), 64'd0);
    chk("arst_word", 64'(bus.setWord), 64'd0);
    chk("arst_guess", 64'(bus.guess), 64'd0);
    chk("arst_mask", 64'(bus.used_mask), 64'd0);
    chk("arst_count", 64'(bus.letter_count), 64'd0);
    @(negedge clk);
    nRst = 1'b1;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hangman_input_loader.md
# hangman_input_loader

Upstream front end for the hangman game logic stage. Turns a stream of received ASCII bytes into two things: the 40-bit secret word during the host phase, and single-letter guesses during play. It strobes `toggle_state` to start the round. It also filters bytes so the game logic only ever sees a new, uppercase, never-before-guessed letter, held stable while the logic is ready.

## Interface
- Parameters: none (word length fixed at 5 letters, 8 bits each).
- `clk` in 1: system clock.
- `nRst` in 1: asynchronous, active-low reset.
- `rx_data` in 8: received ASCII byte; valid only when `rx_valid`=1.
- `rx_valid` in 1: one-cycle strobe marking `rx_data`.
- `game_rdy` in 1: game logic can accept a new guess.
- `game_over` in 1: round finished (win or loss indication from the game logic).
- `setWord` out 40: secret word; first letter in [39:32], fifth in [7:0].
- `guess` out 8: current guess, uppercase ASCII.
- `toggle_state` out 1: one-cycle pulse that starts the round.
- `letter_count` out 3: letters entered so far, 0..5.
- `used_mask` out 26: bit i set means letter 'A'+i has already been guessed.
- `guess_new` out 1: pulse, `guess` was updated.
- `dup_guess` out 1: pulse, guess rejected as a repeat.
- `drop` out 1: pulse, byte discarded (busy, or ignored character).
- `phase` out 2: ENTRY=0, START=1, PLAY=2, DONE=3.

## Operation
- Letter normalisation:
  - 'a'..'z' (0x61–0x7A) is mapped to uppercase by subtracting 0x20.
  - 'A'..'Z' is passed through unchanged.
  - Letter index = upper − 0x41, range 0..25.
- Escape (0x1B) with `rx_valid`, in any phase, returns to ENTRY:
  - `setWord`, `guess`, `letter_count` and `used_mask` are cleared.
  - Escape takes priority over every other event.
- ENTRY phase:
  - Letter with `letter_count`<5: `setWord <= {setWord[31:0], upper}`, count +1.
  - Letter with `letter_count`==5: `drop` pulses, nothing else changes.
  - Backspace (0x08) with count>0: `setWord <= {8'h00, setWord[39:8]}`, count −1.
  - Backspace with count==0: `drop` pulses.
  - Enter (0x0D) with count==5: go to START.
  - Enter with count<5: `drop` pulses.
  - Any other byte: `drop` pulses.
- START phase:
  - Lasts exactly one cycle; `toggle_state`=1 during it.
  - `used_mask` and `guess` are cleared, then the block goes to PLAY.
- PLAY phase:
  - `game_over`=1 moves to DONE next cycle; any byte arriving that cycle is dropped.
  - Otherwise, a letter with `game_rdy`=0: `drop` pulses.
  - Otherwise, a letter whose `used_mask` bit is already set: `dup_guess` pulses, `guess` unchanged.
  - Otherwise, a letter: `guess <= upper`, mask bit is set, `guess_new` pulses.
  - Non-letters other than Escape: `drop` pulses.
- DONE phase:
  - `guess` and `setWord` are held.
  - Only Escape has an effect; all other bytes pulse `drop`.
- `setWord` is frozen outside ENTRY. `guess` changes only on accepted guesses, so it stays stable throughout the game logic's letter-compare sweep.

## Timing
- Reset values:
  - `phase`=ENTRY.
  - `setWord`=0, `guess`=0, `letter_count`=0, `used_mask`=0.
  - All pulse outputs 0, `toggle_state` 0.
- All outputs are registered; an input byte sampled at edge N is reflected after edge N.
- Pulses (`guess_new`, `dup_guess`, `drop`, `toggle_state`) are high for exactly one cycle.
- Enter accepted at edge N: `toggle_state` is high in the cycle following edge N+1 (the START cycle). `phase`=PLAY after edge N+2.
- Back-to-back `rx_valid` on consecutive cycles is fully supported; one byte is processed per cycle.
- Reset asserted mid-operation returns all state and outputs to reset values immediately (asynchronous).

## Test plan
- Word entry:
  - Stimulus: reset, then bytes "h","e","l","l","o", Enter.
  - Required: `setWord`=0x48454C4C4F, `letter_count`=5, a single `toggle_state` pulse, `phase`=2.
- Backspace and overflow:
  - Stimulus: "ABCDEF" then Backspace.
  - Required: the 6th letter pulses `drop`. After Backspace, `setWord`=0x0041424344 and count=4. An Enter sent now pulses `drop`.
- Guess filter:
  - Stimulus: in PLAY with `game_rdy`=1, send "q" then "Q".
  - Required: `guess`=0x51 with one `guess_new` pulse; the second byte gives `dup_guess`; `used_mask` bit 16 is set.
- Busy drop:
  - Stimulus: `game_rdy`=0, send "Z".
  - Required: `drop` pulse, `guess` unchanged, `used_mask` bit 25 clear.
- End and restart:
  - Stimulus: `game_over`=1 in the same cycle as "B", then Escape.
  - Required: "B" is dropped and `phase`=3; after Escape, `phase`=0 and all registers read 0.
- Asynchronous reset:
  - Stimulus: assert `nRst` low while in PLAY.
  - Required: outputs reach reset values without waiting for a clock edge.
